rob_gen: RTL and testbench
==========================

Name: rob_gen

Overview:
- Parametrised reorder buffer. Successor of the fixed-width ROB: entry count and dispatch, complete and retire channel counts are generic.
- Adds in-order branch-mispredict detection at retire, with a full flush.
- Sits between dispatch (allocation), CDB (completion), and the AMT/free list (retirement). Issues ROB indices to the RS.

Parameters:
- ENTRY_NUM, 32, ROB depth; power of 2, >=4.
- DP_NUM, 2, dispatch channels.
- CDB_NUM, 2, completion channels.
- RT_NUM, 2, retire channels.
- ARCH_REG_IDX_WIDTH, 5, architectural register index width.
- TAG_IDX_WIDTH, 6, physical tag width.
- PC_WIDTH, 32, PC width.
- IDX_W, $clog2(ENTRY_NUM), derived ROB index width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low.
- dp_en_i  in  DP_NUM  per-channel dispatch enable; must be thermometer (lowest channels first).
- dp_pc_i  in  DP_NUM*PC_WIDTH  PC per channel.
- dp_arch_reg_i  in  DP_NUM*ARCH_REG_IDX_WIDTH  destination architectural register.
- dp_tag_i  in  DP_NUM*TAG_IDX_WIDTH  new physical tag.
- dp_tag_old_i  in  DP_NUM*TAG_IDX_WIDTH  previous tag.
- dp_br_predict_i  in  DP_NUM  predicted taken (0 for non-branch).
- rob_ready_o  out  DP_NUM  thermometer: bit n=1 when the ROB can accept n+1 instructions.
- rob_idx_o  out  DP_NUM*IDX_W  index allocated to each channel.
- cdb_valid_i  in  CDB_NUM  completion valid.
- cdb_rob_idx_i  in  CDB_NUM*IDX_W  completing entry.
- cdb_br_result_i  in  CDB_NUM  actual branch outcome.
- rt_valid_o  out  RT_NUM  retire valid; thermometer.
- rt_arch_reg_o  out  RT_NUM*ARCH_REG_IDX_WIDTH  to AMT.
- rt_tag_o  out  RT_NUM*TAG_IDX_WIDTH  to AMT.
- rt_tag_old_o  out  RT_NUM*TAG_IDX_WIDTH  to free list.
- rt_pc_o  out  RT_NUM*PC_WIDTH  retired PC.
- br_flush_o  out  1  mispredict flush pulse.
- exception_i  in  1  external flush request.

Behaviour:
- State:
  - head/tail pointers of IDX_W+1 bits; the extra bit is the wrap bit.
  - Count = tail-head, range 0..ENTRY_NUM.
  - Per entry: valid, complete, br_predict, br_result, pc, arch_reg, tag, tag_old.
- Reset (rst_i=0 at posedge): head=tail=0; all valid/complete cleared.
  - Outputs then: rt_valid_o=0, br_flush_o=0, rob_ready_o=all 1s, rob_idx_o[n]=n.
- Dispatch:
  - rob_ready_o[n] = (ENTRY_NUM-count) > n, from registered count only; the same-cycle retire is not counted (but see Optional Feature).
  - rob_idx_o[n] = tail+n, modulo ENTRY_NUM.
  - Enabled channels write their entries at posedge; tail += popcount(dp_en_i).
  - Enabling a channel whose rob_ready_o bit is 0 is illegal; it is dropped and flagged by assertion.
- Complete:
  - At posedge, each valid CDB channel sets complete and br_result for its entry.
  - Completion of an invalid entry is ignored.
  - Duplicate indices across channels: the highest channel's br_result wins.
- Retire (combinational from registered state):
  - Channel k is valid iff entries head..head+k are all valid and complete, and no earlier channel in this cycle is a mispredict.
  - Mispredict: complete entry with br_result != br_predict. It retires (rt_valid_o=1 on its channel) in the same cycle br_flush_o=1.
  - head += retire count at posedge.
  - Latency: a CDB completion at edge N can retire in the cycle after edge N.
- Flush:
  - On a br_flush_o cycle, at posedge: all entries invalidated; head = tail = head + retired count; any dispatch that cycle is dropped.
  - exception_i=1: same flush at posedge. Retire outputs are forced 0 that cycle; br_flush_o=0.
- Boundaries:
  - Full (count=ENTRY_NUM): rob_ready_o=0 even if retiring.
  - Empty: rt_valid_o=0.
  - Pointer wrap is handled by the wrap bit; full/empty are distinguished by it.
  - Simultaneous dispatch and retire on a full ROB: only the retire takes effect.
  - Reset mid-operation discards all state.

Optional Feature:
- ROB_RETIRE_BYPASS_EN defined: rob_ready_o is computed from count minus this cycle's retire count, so a full ROB accepts dispatch into slots freed in the same cycle. Forced to 0 on flush cycles.
- Undefined: rob_ready_o uses the registered count only, as above.

Decomposition:
- Shared package: entry struct (ROB_ENTRY), channel structs (DP_ROB, ROB_DP, ROB_RS, CDB, ROB_AMT, ROB_FL) and default width constants.
- Sub-module rob_retire_sel: computes the thermometer retire vector and the mispredict position from RT_NUM head-window entries.

Test Plan:
- Reset, then dispatch 1 per cycle for 32 cycles -> rob_idx_o[0] goes 0..31; rob_ready_o=2'b00 at count 32.
- Fill, complete indices in reverse order 31..0 -> zero retires until idx 0 completes; then 2 per cycle in program order; arch_reg/tag/tag_old match dispatch order.
- Dispatch 2 branches (predict 0); complete idx1 with br_result 0, then idx0 with br_result 1 -> idx0 retires with br_flush_o=1; idx1 does not retire; next cycle count=0, rob_idx_o[0]=1.
- Pointer wrap: 40 dispatch/retire rounds at 2-wide -> indices wrap 31->0; no lost or duplicated retires; count never exceeds 32.
- exception_i=1 with 10 entries, 3 complete -> rt_valid_o=0 that cycle; next cycle empty, rob_ready_o all 1s.
- Full ROB with head-pair complete and ROB_RETIRE_BYPASS_EN defined -> rob_ready_o=2'b11 and 2 dispatches accepted that cycle. Undefined -> 2'b00.

Source files
------------

// File: rtl/rob_gen_pkg.sv
// Shared types and default widths for the parametrised reorder buffer.
// The channel structs describe each interface at the default widths.
// Optional build macro: ROB_RETIRE_BYPASS_EN (see rob_gen.sv).
package rob_gen_pkg;

    localparam int ROB_ENTRY_NUM_DEF          = 32;
    localparam int ROB_DP_NUM_DEF             = 2;
    localparam int ROB_CDB_NUM_DEF            = 2;
    localparam int ROB_RT_NUM_DEF             = 2;
    localparam int ROB_ARCH_REG_IDX_WIDTH_DEF = 5;
    localparam int ROB_TAG_IDX_WIDTH_DEF      = 6;
    localparam int ROB_PC_WIDTH_DEF           = 32;
    localparam int ROB_IDX_WIDTH_DEF          = $clog2(ROB_ENTRY_NUM_DEF);

    // One reorder buffer entry
    typedef struct packed {
        logic                                  valid;
        logic                                  complete;
        logic                                  br_predict;
        logic                                  br_result;
        logic [ROB_PC_WIDTH_DEF-1:0]           pc;
        logic [ROB_ARCH_REG_IDX_WIDTH_DEF-1:0] arch_reg;
        logic [ROB_TAG_IDX_WIDTH_DEF-1:0]      tag;
        logic [ROB_TAG_IDX_WIDTH_DEF-1:0]      tag_old;
    } ROB_ENTRY;

    // Dispatch -> ROB, one channel
    typedef struct packed {
        logic                                  dp_en;
        logic [ROB_PC_WIDTH_DEF-1:0]           pc;
        logic [ROB_ARCH_REG_IDX_WIDTH_DEF-1:0] arch_reg;
        logic [ROB_TAG_IDX_WIDTH_DEF-1:0]      tag;
        logic [ROB_TAG_IDX_WIDTH_DEF-1:0]      tag_old;
        logic                                  br_predict;
    } DP_ROB;

    // ROB -> dispatch, one channel
    typedef struct packed {
        logic rob_ready;
    } ROB_DP;

    // ROB -> reservation station, one channel
    typedef struct packed {
        logic [ROB_IDX_WIDTH_DEF-1:0] rob_idx;
    } ROB_RS;

    // Common data bus completion, one channel
    typedef struct packed {
        logic                         valid;
        logic [ROB_IDX_WIDTH_DEF-1:0] rob_idx;
        logic                         br_result;
    } CDB;

    // ROB -> architectural map table, one retire channel
    typedef struct packed {
        logic                                  valid;
        logic [ROB_ARCH_REG_IDX_WIDTH_DEF-1:0] arch_reg;
        logic [ROB_TAG_IDX_WIDTH_DEF-1:0]      tag;
    } ROB_AMT;

    // ROB -> free list, one retire channel
    typedef struct packed {
        logic                             valid;
        logic [ROB_TAG_IDX_WIDTH_DEF-1:0] tag_old;
    } ROB_FL;

endpackage

// File: rtl/rob_gen_retire_sel.sv
// Retire selection over the head window of the reorder buffer.
// Produces a thermometer retire vector and a one-hot mispredict marker;
// retirement stops after the first mispredicted branch.
module rob_retire_sel #(
    parameter int RT_NUM = 2
) (
    input  logic [RT_NUM-1:0] win_valid,
    input  logic [RT_NUM-1:0] win_complete,
    input  logic [RT_NUM-1:0] win_br_predict,
    input  logic [RT_NUM-1:0] win_br_result,
    input  logic              hold,
    output logic [RT_NUM-1:0] rt_valid,
    output logic [RT_NUM-1:0] mp_hit
);

    logic chain;

    // Walk the window in program order; a not-ready entry or a mispredict ends the run
    always_comb begin
        rt_valid = '0;
        mp_hit   = '0;
        chain    = 1'b1;
        for (int k = 0; k < RT_NUM; k++) begin
            if (chain && win_valid[k] && win_complete[k]) begin
                rt_valid[k] = 1'b1;
                if (win_br_result[k] != win_br_predict[k]) begin
                    mp_hit[k] = 1'b1;
                    chain     = 1'b0;
                end
            end else begin
                chain = 1'b0;
            end
        end
        if (hold) begin
            rt_valid = '0;
            mp_hit   = '0;
        end
    end

endmodule

// File: rtl/rob_gen.sv
// Parametrised reorder buffer with in-order mispredict detection at retire.
// Optional build macro ROB_RETIRE_BYPASS_EN: rob_ready_o also counts the slots
// retired in the same cycle (forced to 0 on flush cycles).
module rob_gen
    import rob_gen_pkg::*;
#(
    parameter int ENTRY_NUM          = ROB_ENTRY_NUM_DEF,
    parameter int DP_NUM             = ROB_DP_NUM_DEF,
    parameter int CDB_NUM            = ROB_CDB_NUM_DEF,
    parameter int RT_NUM             = ROB_RT_NUM_DEF,
    parameter int ARCH_REG_IDX_WIDTH = ROB_ARCH_REG_IDX_WIDTH_DEF,
    parameter int TAG_IDX_WIDTH      = ROB_TAG_IDX_WIDTH_DEF,
    parameter int PC_WIDTH           = ROB_PC_WIDTH_DEF,
    parameter int IDX_W              = $clog2(ENTRY_NUM)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [DP_NUM-1:0]                    dp_en_i,
    input  logic [DP_NUM*PC_WIDTH-1:0]           dp_pc_i,
    input  logic [DP_NUM*ARCH_REG_IDX_WIDTH-1:0] dp_arch_reg_i,
    input  logic [DP_NUM*TAG_IDX_WIDTH-1:0]      dp_tag_i,
    input  logic [DP_NUM*TAG_IDX_WIDTH-1:0]      dp_tag_old_i,
    input  logic [DP_NUM-1:0]                    dp_br_predict_i,
    output logic [DP_NUM-1:0]                    rob_ready_o,
    output logic [DP_NUM*IDX_W-1:0]              rob_idx_o,
    input  logic [CDB_NUM-1:0]                   cdb_valid_i,
    input  logic [CDB_NUM*IDX_W-1:0]             cdb_rob_idx_i,
    input  logic [CDB_NUM-1:0]                   cdb_br_result_i,
    output logic [RT_NUM-1:0]                    rt_valid_o,
    output logic [RT_NUM*ARCH_REG_IDX_WIDTH-1:0] rt_arch_reg_o,
    output logic [RT_NUM*TAG_IDX_WIDTH-1:0]      rt_tag_o,
    output logic [RT_NUM*TAG_IDX_WIDTH-1:0]      rt_tag_old_o,
    output logic [RT_NUM*PC_WIDTH-1:0]           rt_pc_o,
    output logic                                 br_flush_o,
    input  logic                                 exception_i
);

    localparam int PTR_W = IDX_W + 1;

    // Pointers carry an extra wrap bit so full and empty are distinct
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [PTR_W-1:0] count_w;
    logic [PTR_W-1:0] rt_cnt_w;
    logic [PTR_W-1:0] dp_cnt_w;

    // Per-entry status flags
    logic [ENTRY_NUM-1:0] valid_reg, valid_next;
    logic [ENTRY_NUM-1:0] complete_reg, complete_next;
    logic [ENTRY_NUM-1:0] br_predict_reg, br_predict_next;
    logic [ENTRY_NUM-1:0] br_result_reg, br_result_next;

    // Per-entry payload, written only at dispatch
    logic [PC_WIDTH-1:0]           pc_reg       [ENTRY_NUM];
    logic [ARCH_REG_IDX_WIDTH-1:0] arch_reg_reg [ENTRY_NUM];
    logic [TAG_IDX_WIDTH-1:0]      tag_reg      [ENTRY_NUM];
    logic [TAG_IDX_WIDTH-1:0]      tag_old_reg  [ENTRY_NUM];

    logic [IDX_W-1:0]  dp_idx_w  [DP_NUM];
    logic [IDX_W-1:0]  win_idx_w [RT_NUM];
    logic [RT_NUM-1:0] win_valid_w, win_complete_w, win_br_predict_w, win_br_result_w;
    logic [RT_NUM-1:0] rt_valid_w, mp_hit_w;
    logic [DP_NUM-1:0] dp_acc_w;
    logic              flush_w;

    assign count_w = tail_reg - head_reg;

    genvar gi;

    // Dispatch slot indices, one per channel starting at the tail
    for (gi = 0; gi < DP_NUM; gi++) begin : g_dp_idx
        assign dp_idx_w[gi]                    = tail_reg[IDX_W-1:0] + IDX_W'(gi);
        assign rob_idx_o[gi*IDX_W +: IDX_W]    = dp_idx_w[gi];
    end

    // Head window: the entries eligible to retire this cycle
    for (gi = 0; gi < RT_NUM; gi++) begin : g_win
        assign win_idx_w[gi]        = head_reg[IDX_W-1:0] + IDX_W'(gi);
        assign win_valid_w[gi]      = valid_reg[win_idx_w[gi]];
        assign win_complete_w[gi]   = complete_reg[win_idx_w[gi]];
        assign win_br_predict_w[gi] = br_predict_reg[win_idx_w[gi]];
        assign win_br_result_w[gi]  = br_result_reg[win_idx_w[gi]];
        assign rt_arch_reg_o[gi*ARCH_REG_IDX_WIDTH +: ARCH_REG_IDX_WIDTH] = arch_reg_reg[win_idx_w[gi]];
        assign rt_tag_o[gi*TAG_IDX_WIDTH +: TAG_IDX_WIDTH]                = tag_reg[win_idx_w[gi]];
        assign rt_tag_old_o[gi*TAG_IDX_WIDTH +: TAG_IDX_WIDTH]            = tag_old_reg[win_idx_w[gi]];
        assign rt_pc_o[gi*PC_WIDTH +: PC_WIDTH]                           = pc_reg[win_idx_w[gi]];
    end

    rob_retire_sel #(
        .RT_NUM (RT_NUM)
    ) u_retire_sel (
        .win_valid      (win_valid_w),
        .win_complete   (win_complete_w),
        .win_br_predict (win_br_predict_w),
        .win_br_result  (win_br_result_w),
        .hold           (exception_i),
        .rt_valid       (rt_valid_w),
        .mp_hit         (mp_hit_w)
    );

    assign rt_valid_o = rt_valid_w;
    assign br_flush_o = |mp_hit_w;
    assign flush_w    = br_flush_o | exception_i;

    // Free-slot check per dispatch channel
    always_comb begin
        int free_w;
        rob_ready_o = '0;
`ifdef ROB_RETIRE_BYPASS_EN
        free_w = ENTRY_NUM - int'(count_w) + int'(rt_cnt_w);
        for (int n = 0; n < DP_NUM; n++) begin
            rob_ready_o[n] = !flush_w && (free_w > n);
        end
`else
        free_w = ENTRY_NUM - int'(count_w);
        for (int n = 0; n < DP_NUM; n++) begin
            rob_ready_o[n] = (free_w > n);
        end
`endif
    end

    // Accepted dispatches and retire/dispatch counts; a flush drops all dispatch
    always_comb begin
        dp_acc_w = flush_w ? '0 : (dp_en_i & rob_ready_o);
        rt_cnt_w = '0;
        dp_cnt_w = '0;
        for (int k = 0; k < RT_NUM; k++) begin
            rt_cnt_w = rt_cnt_w + PTR_W'(rt_valid_w[k]);
        end
        for (int n = 0; n < DP_NUM; n++) begin
            dp_cnt_w = dp_cnt_w + PTR_W'(dp_acc_w[n]);
        end
        head_next = head_reg + rt_cnt_w;
        tail_next = flush_w ? head_next : (tail_reg + dp_cnt_w);
    end

    // Entry flag updates: retire clears, CDB completes, dispatch allocates, flush wipes
    always_comb begin
        valid_next      = valid_reg;
        complete_next   = complete_reg;
        br_predict_next = br_predict_reg;
        br_result_next  = br_result_reg;
        for (int k = 0; k < RT_NUM; k++) begin
            if (rt_valid_w[k]) begin
                valid_next[win_idx_w[k]] = 1'b0;
            end
        end
        // Ascending order so the highest channel wins on duplicate indices
        for (int c = 0; c < CDB_NUM; c++) begin
            if (cdb_valid_i[c] && valid_reg[cdb_rob_idx_i[c*IDX_W +: IDX_W]]) begin
                complete_next[cdb_rob_idx_i[c*IDX_W +: IDX_W]]  = 1'b1;
                br_result_next[cdb_rob_idx_i[c*IDX_W +: IDX_W]] = cdb_br_result_i[c];
            end
        end
        for (int n = 0; n < DP_NUM; n++) begin
            if (dp_acc_w[n]) begin
                valid_next[dp_idx_w[n]]      = 1'b1;
                complete_next[dp_idx_w[n]]   = 1'b0;
                br_predict_next[dp_idx_w[n]] = dp_br_predict_i[n];
                br_result_next[dp_idx_w[n]]  = 1'b0;
            end
        end
        if (flush_w) begin
            valid_next = '0;
        end
    end

    // Pointer and flag registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            valid_reg    <= '0;
            complete_reg <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            valid_reg    <= valid_next;
            complete_reg <= complete_next;
        end
    end

    // Branch flags need no reset: they are always rewritten on allocation
    always_ff @(posedge clk_i) begin
        br_predict_reg <= br_predict_next;
        br_result_reg  <= br_result_next;
    end

    // Payload storage written by accepted dispatch channels
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < DP_NUM; n++) begin
            if (dp_acc_w[n]) begin
                pc_reg[dp_idx_w[n]]       <= dp_pc_i[n*PC_WIDTH +: PC_WIDTH];
                arch_reg_reg[dp_idx_w[n]] <= dp_arch_reg_i[n*ARCH_REG_IDX_WIDTH +: ARCH_REG_IDX_WIDTH];
                tag_reg[dp_idx_w[n]]      <= dp_tag_i[n*TAG_IDX_WIDTH +: TAG_IDX_WIDTH];
                tag_old_reg[dp_idx_w[n]]  <= dp_tag_old_i[n*TAG_IDX_WIDTH +: TAG_IDX_WIDTH];
            end
        end
    end

    // Dispatching into a slot that was not offered is a protocol error upstream
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            assert ((dp_en_i & ~rob_ready_o) == '0)
                else $error("rob_gen: dispatch enabled on a channel without rob_ready_o");
        end
    end

endmodule

// File: tb/tb_rob_gen.sv
// Directed testbench for rob_gen at default parameters.
// Honours ROB_RETIRE_BYPASS_EN when the design is built with it.
module tb_rob_gen;

    localparam int EN = 32;
    localparam int DN = 2;
    localparam int CN = 2;
    localparam int RN = 2;
    localparam int AW = 5;
    localparam int TW = 6;
    localparam int PW = 32;
    localparam int IW = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [DN-1:0]     dp_en_i;
    logic [DN*PW-1:0]  dp_pc_i;
    logic [DN*AW-1:0]  dp_arch_reg_i;
    logic [DN*TW-1:0]  dp_tag_i;
    logic [DN*TW-1:0]  dp_tag_old_i;
    logic [DN-1:0]     dp_br_predict_i;
    logic [DN-1:0]     rob_ready_o;
    logic [DN*IW-1:0]  rob_idx_o;
    logic [CN-1:0]     cdb_valid_i;
    logic [CN*IW-1:0]  cdb_rob_idx_i;
    logic [CN-1:0]     cdb_br_result_i;
    logic [RN-1:0]     rt_valid_o;
    logic [RN*AW-1:0]  rt_arch_reg_o;
    logic [RN*TW-1:0]  rt_tag_o;
    logic [RN*TW-1:0]  rt_tag_old_o;
    logic [RN*PW-1:0]  rt_pc_o;
    logic              br_flush_o;
    logic              exception_i;

    int total = 0;
    int bad   = 0;

    rob_gen #(
        .ENTRY_NUM(EN), .DP_NUM(DN), .CDB_NUM(CN), .RT_NUM(RN),
        .ARCH_REG_IDX_WIDTH(AW), .TAG_IDX_WIDTH(TW), .PC_WIDTH(PW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dp_en_i(dp_en_i), .dp_pc_i(dp_pc_i), .dp_arch_reg_i(dp_arch_reg_i),
        .dp_tag_i(dp_tag_i), .dp_tag_old_i(dp_tag_old_i), .dp_br_predict_i(dp_br_predict_i),
        .rob_ready_o(rob_ready_o), .rob_idx_o(rob_idx_o),
        .cdb_valid_i(cdb_valid_i), .cdb_rob_idx_i(cdb_rob_idx_i), .cdb_br_result_i(cdb_br_result_i),
        .rt_valid_o(rt_valid_o), .rt_arch_reg_o(rt_arch_reg_o), .rt_tag_o(rt_tag_o),
        .rt_tag_old_o(rt_tag_old_o), .rt_pc_o(rt_pc_o), .br_flush_o(br_flush_o),
        .exception_i(exception_i)
    );

    always #5 clk_i = ~clk_i;

    // Wait for the next rising edge, then move clear of it
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        dp_en_i         = '0;
        dp_pc_i         = '0;
        dp_arch_reg_i   = '0;
        dp_tag_i        = '0;
        dp_tag_old_i    = '0;
        dp_br_predict_i = '0;
        cdb_valid_i     = '0;
        cdb_rob_idx_i   = '0;
        cdb_br_result_i = '0;
        exception_i     = 1'b0;
    endtask

    task automatic set_dp(input int ch, input logic [PW-1:0] pc, input logic [AW-1:0] ar,
                          input logic [TW-1:0] tg, input logic [TW-1:0] to, input logic br);
        dp_en_i[ch]                  = 1'b1;
        dp_pc_i[ch*PW +: PW]         = pc;
        dp_arch_reg_i[ch*AW +: AW]   = ar;
        dp_tag_i[ch*TW +: TW]        = tg;
        dp_tag_old_i[ch*TW +: TW]    = to;
        dp_br_predict_i[ch]          = br;
    endtask

    task automatic set_cdb(input int ch, input logic [IW-1:0] idx, input logic res);
        cdb_valid_i[ch]              = 1'b1;
        cdb_rob_idx_i[ch*IW +: IW]   = idx;
        cdb_br_result_i[ch]          = res;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL reset_rt_valid got=%b exp=00", rt_valid_o); end
        total++; if (br_flush_o !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b exp=0", br_flush_o); end
        total++; if (rob_ready_o !== 2'b11) begin bad++; $display("FAIL reset_ready got=%b exp=11", rob_ready_o); end
        total++; if (rob_idx_o[IW-1:0] !== 5'd0) begin bad++; $display("FAIL reset_idx0 got=%0d exp=0", rob_idx_o[IW-1:0]); end
        total++; if (rob_idx_o[2*IW-1:IW] !== 5'd1) begin bad++; $display("FAIL reset_idx1 got=%0d exp=1", rob_idx_o[2*IW-1:IW]); end
        $display("reset: ready=%b idx0=%0d idx1=%0d", rob_ready_o, rob_idx_o[IW-1:0], rob_idx_o[2*IW-1:IW]);
        tick();
    endtask

    // Single-wide fill of all 32 entries; entry i holds arch=i, tag=i+32, tag_old=i
    task automatic test_fill();
        logic [1:0] exp_ready;
        for (int i = 0; i < 32; i++) begin
            idle_inputs();
            set_dp(0, 32'h1000 + 32'(4 * i), AW'(i), TW'(i + 32), TW'(i), 1'b0);
            #1;
            exp_ready = (i < 31) ? 2'b11 : 2'b01;
            total++; if (rob_idx_o[IW-1:0] !== IW'(i)) begin bad++; $display("FAIL fill_idx got=%0d exp=%0d", rob_idx_o[IW-1:0], i); end
            total++; if (rob_ready_o !== exp_ready) begin bad++; $display("FAIL fill_ready i=%0d got=%b exp=%b", i, rob_ready_o, exp_ready); end
            $display("dispatch idx=%0d ready=%b", rob_idx_o[IW-1:0], rob_ready_o);
            tick();
        end
        idle_inputs();
        #1;
        total++; if (rob_ready_o !== 2'b00) begin bad++; $display("FAIL full_ready got=%b exp=00", rob_ready_o); end
        total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL full_rt_valid got=%b exp=00", rt_valid_o); end
    endtask

    // Complete 31..0; nothing retires until the head completes, then 2 per cycle
    task automatic test_reverse_complete();
        logic [1:0] exp_full_ready;
`ifdef ROB_RETIRE_BYPASS_EN
        exp_full_ready = 2'b11;
`else
        exp_full_ready = 2'b00;
`endif
        for (int k = 31; k >= 0; k--) begin
            idle_inputs();
            set_cdb(0, IW'(k), 1'b0);
            #1;
            total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL rev_early_retire k=%0d got=%b exp=00", k, rt_valid_o); end
            tick();
        end
        idle_inputs();
        for (int j = 0; j < 16; j++) begin
            #1;
            total++; if (rt_valid_o !== 2'b11) begin bad++; $display("FAIL rev_rt_valid j=%0d got=%b exp=11", j, rt_valid_o); end
            total++; if (rt_arch_reg_o[AW-1:0] !== AW'(2*j)) begin bad++; $display("FAIL rev_arch0 got=%0d exp=%0d", rt_arch_reg_o[AW-1:0], 2*j); end
            total++; if (rt_arch_reg_o[2*AW-1:AW] !== AW'(2*j+1)) begin bad++; $display("FAIL rev_arch1 got=%0d exp=%0d", rt_arch_reg_o[2*AW-1:AW], 2*j+1); end
            total++; if (rt_tag_o[TW-1:0] !== TW'(2*j+32)) begin bad++; $display("FAIL rev_tag0 got=%0d exp=%0d", rt_tag_o[TW-1:0], 2*j+32); end
            total++; if (rt_tag_old_o[2*TW-1:TW] !== TW'(2*j+1)) begin bad++; $display("FAIL rev_tag_old1 got=%0d exp=%0d", rt_tag_old_o[2*TW-1:TW], 2*j+1); end
            total++; if (rt_pc_o[PW-1:0] !== 32'h1000 + 32'(8*j)) begin bad++; $display("FAIL rev_pc0 got=%h exp=%h", rt_pc_o[PW-1:0], 32'h1000 + 32'(8*j)); end
            if (j == 0) begin
                total++; if (rob_ready_o !== exp_full_ready) begin bad++; $display("FAIL full_retire_ready got=%b exp=%b", rob_ready_o, exp_full_ready); end
            end
            $display("retire pair arch=%0d,%0d tag=%0d", rt_arch_reg_o[AW-1:0], rt_arch_reg_o[2*AW-1:AW], rt_tag_o[TW-1:0]);
            tick();
        end
        #1;
        total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL drained_rt_valid got=%b exp=00", rt_valid_o); end
        total++; if (rob_ready_o !== 2'b11) begin bad++; $display("FAIL drained_ready got=%b exp=11", rob_ready_o); end
        total++; if (rob_idx_o[IW-1:0] !== 5'd0) begin bad++; $display("FAIL drained_idx got=%0d exp=0", rob_idx_o[IW-1:0]); end
    endtask

    // Two branches predicted not-taken; the older one turns out taken
    task automatic test_mispredict();
        idle_inputs();
        set_dp(0, 32'h3000, 5'd3, 6'd10, 6'd11, 1'b0);
        set_dp(1, 32'h3004, 5'd4, 6'd12, 6'd13, 1'b0);
        #1;
        total++; if (rob_idx_o !== {5'd1, 5'd0}) begin bad++; $display("FAIL mp_idx got=%h exp=%h", rob_idx_o, {5'd1, 5'd0}); end
        tick();
        idle_inputs();
        set_cdb(0, 5'd1, 1'b0);
        #1;
        total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL mp_before got=%b exp=00", rt_valid_o); end
        tick();
        idle_inputs();
        set_cdb(0, 5'd0, 1'b1);
        tick();
        idle_inputs();
`ifndef ROB_RETIRE_BYPASS_EN
        set_dp(0, 32'h3008, 5'd5, 6'd14, 6'd15, 1'b0);
`endif
        #1;
        total++; if (rt_valid_o !== 2'b01) begin bad++; $display("FAIL mp_rt_valid got=%b exp=01", rt_valid_o); end
        total++; if (br_flush_o !== 1'b1) begin bad++; $display("FAIL mp_flush got=%b exp=1", br_flush_o); end
        total++; if (rt_pc_o[PW-1:0] !== 32'h3000) begin bad++; $display("FAIL mp_pc got=%h exp=3000", rt_pc_o[PW-1:0]); end
        $display("mispredict retire pc=%h flush=%b", rt_pc_o[PW-1:0], br_flush_o);
        tick();
        idle_inputs();
        #1;
        total++; if (rob_ready_o !== 2'b11) begin bad++; $display("FAIL mp_after_ready got=%b exp=11", rob_ready_o); end
        total++; if (rob_idx_o[IW-1:0] !== 5'd1) begin bad++; $display("FAIL mp_after_idx got=%0d exp=1", rob_idx_o[IW-1:0]); end
        total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL mp_after_rt got=%b exp=00", rt_valid_o); end
        total++; if (br_flush_o !== 1'b0) begin bad++; $display("FAIL mp_after_flush got=%b exp=0", br_flush_o); end
    endtask

    // 40 rounds of 2-wide dispatch/complete/retire, wrapping the pointers
    task automatic test_wrap();
        int base;
        int s;
        base = 1;
        for (int r = 0; r < 40; r++) begin
            s = 2 * r;
            idle_inputs();
            set_dp(0, 32'h2000 + 32'(4*s), AW'(s), TW'(s), TW'(s + 7), 1'b0);
            set_dp(1, 32'h2000 + 32'(4*(s+1)), AW'(s + 1), TW'(s + 1), TW'(s + 8), 1'b0);
            #1;
            total++; if (rob_idx_o[IW-1:0] !== IW'(base)) begin bad++; $display("FAIL wrap_idx0 r=%0d got=%0d exp=%0d", r, rob_idx_o[IW-1:0], base % 32); end
            total++; if (rob_idx_o[2*IW-1:IW] !== IW'(base + 1)) begin bad++; $display("FAIL wrap_idx1 r=%0d got=%0d exp=%0d", r, rob_idx_o[2*IW-1:IW], (base + 1) % 32); end
            total++; if (rob_ready_o !== 2'b11) begin bad++; $display("FAIL wrap_ready r=%0d got=%b exp=11", r, rob_ready_o); end
            tick();
            idle_inputs();
            set_cdb(0, IW'(base), 1'b0);
            set_cdb(1, IW'(base + 1), 1'b0);
            #1;
            total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL wrap_early r=%0d got=%b exp=00", r, rt_valid_o); end
            tick();
            idle_inputs();
            #1;
            total++; if (rt_valid_o !== 2'b11) begin bad++; $display("FAIL wrap_rt_valid r=%0d got=%b exp=11", r, rt_valid_o); end
            total++; if (rt_tag_o !== {TW'(s + 1), TW'(s)}) begin bad++; $display("FAIL wrap_tag r=%0d got=%h exp=%h", r, rt_tag_o, {TW'(s + 1), TW'(s)}); end
            total++; if (rt_pc_o[2*PW-1:PW] !== 32'h2000 + 32'(4*(s+1))) begin bad++; $display("FAIL wrap_pc1 r=%0d got=%h exp=%h", r, rt_pc_o[2*PW-1:PW], 32'h2000 + 32'(4*(s+1))); end
            $display("wrap round %0d retire idx=%0d,%0d", r, base % 32, (base + 1) % 32);
            tick();
            base = base + 2;
        end
        #1;
        total++; if (rob_idx_o[IW-1:0] !== 5'd17) begin bad++; $display("FAIL wrap_end_idx got=%0d exp=17", rob_idx_o[IW-1:0]); end
    endtask

    // Ten entries, three complete (two at the head), then an external flush
    task automatic test_exception();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            set_dp(0, 32'h4000 + 32'(8*c), AW'(2*c), TW'(2*c), TW'(2*c), 1'b0);
            set_dp(1, 32'h4004 + 32'(8*c), AW'(2*c+1), TW'(2*c+1), TW'(2*c+1), 1'b0);
            tick();
        end
        idle_inputs();
        set_cdb(0, 5'd19, 1'b0);
        #1;
        total++; if (rob_ready_o !== 2'b11) begin bad++; $display("FAIL exc_ready10 got=%b exp=11", rob_ready_o); end
        tick();
        idle_inputs();
        set_cdb(0, 5'd17, 1'b0);
        set_cdb(1, 5'd18, 1'b0);
        tick();
        idle_inputs();
        exception_i = 1'b1;
        #1;
        total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL exc_rt_valid got=%b exp=00", rt_valid_o); end
        total++; if (br_flush_o !== 1'b0) begin bad++; $display("FAIL exc_br_flush got=%b exp=0", br_flush_o); end
        $display("exception cycle rt_valid=%b", rt_valid_o);
        tick();
        idle_inputs();
        #1;
        total++; if (rob_ready_o !== 2'b11) begin bad++; $display("FAIL exc_after_ready got=%b exp=11", rob_ready_o); end
        total++; if (rob_idx_o[IW-1:0] !== 5'd17) begin bad++; $display("FAIL exc_after_idx got=%0d exp=17", rob_idx_o[IW-1:0]); end
        total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL exc_after_rt got=%b exp=00", rt_valid_o); end
    endtask

    // Both CDB channels hit the same entry; the higher channel's result wins
    task automatic test_cdb_dup();
        idle_inputs();
        set_dp(0, 32'h5000, 5'd7, 6'd20, 6'd21, 1'b1);
        set_dp(1, 32'h5004, 5'd8, 6'd22, 6'd23, 1'b0);
        tick();
        idle_inputs();
        set_cdb(0, 5'd17, 1'b0);
        set_cdb(1, 5'd17, 1'b1);
        tick();
        idle_inputs();
        #1;
        total++; if (rt_valid_o !== 2'b01) begin bad++; $display("FAIL dup_rt_valid got=%b exp=01", rt_valid_o); end
        total++; if (br_flush_o !== 1'b0) begin bad++; $display("FAIL dup_flush got=%b exp=0", br_flush_o); end
        total++; if (rt_pc_o[PW-1:0] !== 32'h5000) begin bad++; $display("FAIL dup_pc got=%h exp=5000", rt_pc_o[PW-1:0]); end
        $display("dup retire pc=%h flush=%b", rt_pc_o[PW-1:0], br_flush_o);
        tick();
        #1;
        total++; if (rt_valid_o !== 2'b00) begin bad++; $display("FAIL dup_after_rt got=%b exp=00", rt_valid_o); end
        total++; if (rob_idx_o[IW-1:0] !== 5'd19) begin bad++; $display("FAIL dup_after_idx got=%0d exp=19", rob_idx_o[IW-1:0]); end
    endtask

    // Reset with a live entry; afterwards a fresh entry lands at index 0
    task automatic test_reset_mid();
        idle_inputs();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        total++; if (rob_idx_o[IW-1:0] !== 5'd0) begin bad++; $display("FAIL rmid_idx got=%0d exp=0", rob_idx_o[IW-1:0]); end
        total++; if (rob_ready_o !== 2'b11) begin bad++; $display("FAIL rmid_ready got=%b exp=11", rob_ready_o); end
        set_dp(0, 32'h6000, 5'd9, 6'd30, 6'd31, 1'b0);
        tick();
        idle_inputs();
        set_cdb(0, 5'd0, 1'b0);
        tick();
        idle_inputs();
        #1;
        total++; if (rt_valid_o !== 2'b01) begin bad++; $display("FAIL rmid_rt_valid got=%b exp=01", rt_valid_o); end
        total++; if (rt_pc_o[PW-1:0] !== 32'h6000) begin bad++; $display("FAIL rmid_pc got=%h exp=6000", rt_pc_o[PW-1:0]); end
        $display("post-reset retire pc=%h", rt_pc_o[PW-1:0]);
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_reverse_complete();
        test_mispredict();
        test_wrap();
        test_exception();
        test_cdb_dup();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound the whole run in case the design stalls
    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
